// File: rtl/cache_def.sv
// ============================================================================
// Module      : cache_def (package)
// Description : Shared cache/memory definitions: line geometry and the
//               request/result structures exchanged between the cache and
//               the line fill unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_def;

    localparam int WORD_WIDTH = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_WIDTH = WORD_WIDTH * LINE_WORDS;

    // Cache miss request: line-aligned internally, low address bits ignored.
    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
    } mem_req_typeI;

    // Assembled line plus a one-cycle completion strobe.
    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic                  ready;
    } mem_result_type;

endpackage

`default_nettype wire

// File: rtl/line_fill_unit.sv
// ============================================================================
// Module      : line_fill_unit
// Description : Fetches one 4-word cache line from main memory, one 32-bit
//               word per bus handshake, and presents the assembled line with
//               a single-cycle ready strobe. A word that is not acknowledged
//               within TIMEOUT cycles aborts the fill (fill_err pulse,
//               remaining words left at zero).
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               mem_req    - miss request (addr, valid), sampled in IDLE only
//               mem_result - line data (held until next accept) and ready
//               bus_addr   - word address to memory
//               bus_rd     - word read request, high only while fetching
//               bus_rdata  - returned word, valid with bus_ack
//               bus_ack    - word-return strobe
//               fill_err   - one-cycle pulse with ready on an aborted fill
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_unit
    import cache_def::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  mem_req_typeI   mem_req,
    output mem_result_type mem_result,
    output logic [31:0]    bus_addr,
    output logic           bus_rd,
    input  logic [31:0]    bus_rdata,
    input  logic           bus_ack,
    output logic           fill_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_read = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Wide enough to hold TIMEOUT itself so the terminal compare never wraps.
    localparam int c_wait_w = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [1:0]          c_last_word = 2'(LINE_WORDS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_timeout;
    logic [1:0]            r_count;
    logic [1:0]            w_count_inc;
    logic [c_wait_w-1:0]   r_wait;
    logic                  r_err;
    logic [LINE_WIDTH-1:0] r_line;
    logic [31:0]           r_base;
    logic [31:0]           r_bus_addr;

    // Line-offset bits of the request address are intentionally dropped.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^mem_req.addr[3:0];

    assign w_count_inc = r_count + 2'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (mem_req.valid) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read: begin
                if (bus_ack) begin
                    if (r_count == c_last_word) begin
                        w_state_nxt = c_st_done;
                    end
                end else if (r_wait == c_wait_last) begin
                    // This idle edge is the TIMEOUT-th one for the word.
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: base/address, word count, wait counter, line buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_line     <= '0;
            r_base     <= 32'd0;
            r_bus_addr <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_err <= 1'b0;
                    if (mem_req.valid) begin
                        r_base     <= {mem_req.addr[31:4], 4'b0000};
                        r_bus_addr <= {mem_req.addr[31:4], 4'b0000};
                        r_count    <= 2'd0;
                        r_wait     <= '0;
                        r_line     <= '0;
                    end
                end
                c_st_read: begin
                    if (bus_ack) begin
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            if (r_count == 2'(i)) begin
                                r_line[i*WORD_WIDTH +: WORD_WIDTH] <= bus_rdata;
                            end
                        end
                        r_count <= w_count_inc;
                        r_wait  <= '0;
                        // Keep the last word address visible after the final
                        // ack instead of stepping past the line.
                        if (r_count != c_last_word) begin
                            r_bus_addr <= r_base + {28'd0, w_count_inc, 2'b00};
                        end
                    end else begin
                        r_wait <= r_wait + c_wait_w'(1);
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    // DONE always returns to IDLE, so the flag clears here.
                    r_err <= 1'b0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, so reset clears them at once.
    // ------------------------------------------------------------------
    always_comb begin
        mem_result.data  = r_line;
        mem_result.ready = (r_state == c_st_done);
        bus_rd           = (r_state == c_st_read);
        bus_addr         = r_bus_addr;
        fill_err         = (r_state == c_st_done) && r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_line_fill_unit.sv
// ============================================================================
// Module      : tb_line_fill_unit
// Description : Scoreboard bench for line_fill_unit. Stimulus pushes the
//               expected line/error and word addresses into queues; a memory
//               responder and a result monitor pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_fill_unit;
    import cache_def::*;

    localparam int c_m_off   = 0;
    localparam int c_m_zero  = 1;
    localparam int c_m_wait  = 2;
    localparam int c_m_tmo   = 3;
    localparam int c_m_stray = 4;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic           clk;
    logic           reset;
    mem_req_typeI   mem_req;
    mem_result_type mem_result;
    logic [31:0]    bus_addr;
    logic           bus_rd;
    logic [31:0]    bus_rdata;
    logic           bus_ack;
    logic           fill_err;

    int          total;
    int          bad;
    int          mode;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    line_fill_unit #(
        .TIMEOUT (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_result (mem_result),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .fill_err   (fill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred or missing, got wrong outcome", name);
    endtask

    // Memory responder: drives ack/rdata at negedge for the next rising edge
    // and checks each acknowledged word address against the expected list.
    initial begin
        logic        prev_rd;
        logic        prev_ack;
        logic [31:0] prev_addr;
        int          wcnt;
        prev_rd   = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 32'd0;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mode == c_m_wait && prev_rd && bus_rd && !prev_ack) begin
                check("addr_hold", {96'd0, bus_addr}, {96'd0, prev_addr});
            end
            prev_rd   = bus_rd;
            prev_addr = bus_addr;
            case (mode)
                c_m_zero: begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_addr;
                end
                c_m_wait: begin
                    if (!bus_rd) begin
                        wcnt    = 0;
                        bus_ack = 1'b0;
                    end else if (wcnt == 3) begin
                        wcnt      = 0;
                        bus_ack   = 1'b1;
                        bus_rdata = bus_addr ^ 32'hA5A5_0000;
                    end else begin
                        wcnt++;
                        bus_ack = 1'b0;
                    end
                end
                c_m_tmo: begin
                    bus_ack   = bus_rd && (bus_addr[3:2] == 2'd0);
                    bus_rdata = 32'hDEAD_BEEF;
                end
                c_m_stray: begin
                    bus_ack   = 1'b1;
                    bus_rdata = 32'hFFFF_FFFF;
                end
                default: begin
                    bus_ack = 1'b0;
                end
            endcase
            prev_ack = bus_ack;
            if (bus_rd && bus_ack) begin
                if (addr_q.size() == 0) begin
                    fail("addr_unexpected");
                end else begin
                    check("bus_addr", {96'd0, bus_addr}, {96'd0, addr_q.pop_front()});
                end
            end
        end
    end

    // Result monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_result.ready) begin
                if (exp_q.size() == 0) begin
                    fail("ready_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("line_data", mem_result.data, e.data);
                    check("fill_err", {127'd0, fill_err}, {127'd0, e.err});
                end
            end else if (fill_err) begin
                fail("err_without_ready");
            end
        end
    end

    task automatic issue(input logic [31:0] addr);
        @(negedge clk);
        mem_req.addr  = addr;
        mem_req.valid = 1'b1;
        @(posedge clk);
        #1;
        mem_req.valid = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (mem_result.ready) return;
        end
        fail("ready_timeout");
    endtask

    task automatic push_line(input logic [31:0] base, input logic [31:0] xmask);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(base + 32'(4 * i));
            e.data[i*32 +: 32] = (base + 32'(4 * i)) ^ xmask;
        end
        e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic found;
        total         = 0;
        bad           = 0;
        mode          = c_m_off;
        reset         = 1'b1;
        mem_req.addr  = 32'd0;
        mem_req.valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus_rd", {127'd0, bus_rd}, 128'd0);
        check("rst_ready", {127'd0, mem_result.ready}, 128'd0);
        check("rst_data", mem_result.data, 128'd0);
        check("rst_bus_addr", {96'd0, bus_addr}, 128'd0);
        reset = 1'b0;

        // Zero-wait fill with latency check
        mode = c_m_zero;
        push_line(32'h0000_1230, 32'd0);
        issue(32'h0000_1234);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("zw_ready_c%0d", k), {127'd0, mem_result.ready}, {127'd0, (k == 4)});
        end
        repeat (2) @(negedge clk);

        // Stray ack in IDLE
        mode = c_m_stray;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stray_bus_rd", {127'd0, bus_rd}, 128'd0);
            check("stray_ready", {127'd0, mem_result.ready}, 128'd0);
        end

        // Wait-state fill
        mode = c_m_wait;
        push_line(32'h0000_ABC0, 32'hA5A5_0000);
        issue(32'h0000_ABC8);
        wait_ready(64);
        repeat (3) @(negedge clk);
        check("ws_data_held", mem_result.data,
              128'hA5A5ABCC_A5A5ABC8_A5A5ABC4_A5A5ABC0);

        // Timeout after word 0
        mode = c_m_tmo;
        addr_q.push_back(32'h0000_5000);
        e.data = {96'd0, 32'hDEAD_BEEF};
        e.err  = 1'b1;
        exp_q.push_back(e);
        issue(32'h0000_5000);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("to_ready_c%0d", k), {127'd0, mem_result.ready}, {127'd0, (k == 9)});
            check($sformatf("to_err_c%0d", k), {127'd0, fill_err}, {127'd0, (k == 9)});
        end

        // Busy ignore: new request while filling
        mode = c_m_wait;
        push_line(32'h0000_2000, 32'hA5A5_0000);
        issue(32'h0000_2004);
        repeat (2) @(negedge clk);
        mem_req.addr  = 32'h0000_9990;
        mem_req.valid = 1'b1;
        repeat (6) @(negedge clk);
        mem_req.valid = 1'b0;
        wait_ready(64);
        repeat (10) @(negedge clk);
        check("busy_no_refill", {127'd0, bus_rd}, 128'd0);

        // Reset mid-fill after two words
        addr_q.push_back(32'h0000_7770);
        addr_q.push_back(32'h0000_7774);
        issue(32'h0000_7770);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus_addr == 32'h0000_7778) found = 1'b1;
        end
        if (!found) fail("rst_mid_two_words");
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_bus_rd", {127'd0, bus_rd}, 128'd0);
        check("rst_mid_ready", {127'd0, mem_result.ready}, 128'd0);
        check("rst_mid_data", mem_result.data, 128'd0);
        check("rst_mid_bus_addr", {96'd0, bus_addr}, 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mode  = c_m_stray;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {127'd0, bus_rd}, 128'd0);
        mode = c_m_zero;
        push_line(32'h0000_1110, 32'd0);
        issue(32'h0000_111C);
        wait_ready(20);

        repeat (5) @(negedge clk);
        check("exp_q_empty", 128'(exp_q.size()), 128'd0);
        check("addr_q_empty", 128'(addr_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
